mouse_cursor_tracker: RTL and testbench
=======================================

MOUSE_CURSOR_TRACKER -- requirements
Module: mouse_cursor_tracker

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, the horizontal pixel count; cursor_x range is 0..SCREEN_W-1.
REQ-002 SHALL have parameter SCREEN_H, default 480, the vertical pixel count; cursor_y range is 0..SCREEN_H-1.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 500000, the maximum clk cycles allowed between bytes of one packet.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port rx_data, input, 8, a received PS/2 mouse byte.
REQ-007 SHALL have port rx_valid, input, 1, a one-cycle strobe qualifying rx_data.
REQ-008 SHALL have ports cursor_x and cursor_y, output, 11 each, the registered cursor position consumed by the cursor overlay stage.
REQ-009 SHALL have ports btn_left and btn_right, output, 1 each, registered button levels.
REQ-010 SHALL have ports left_click and right_click, output, 1 each, one-cycle press pulses.
REQ-011 SHALL have port pkt_valid, output, 1, a one-cycle pulse per applied packet.
REQ-012 SHALL have port sync_err, output, 1, a one-cycle pulse per discarded byte or timed-out packet.

Function
REQ-013 SHALL use the FSM states WAIT_B0, WAIT_B1, WAIT_B2 and UPDATE.
REQ-014 In WAIT_B0, SHALL accept a byte with rx_data[3]=1 as b0 and go to WAIT_B1.
REQ-015 In WAIT_B0, SHALL discard a byte with rx_data[3]=0, stay in WAIT_B0 and pulse sync_err.
REQ-016 On a byte in WAIT_B1, SHALL store it as b1 and go to WAIT_B2.
REQ-017 On a byte in WAIT_B2, SHALL store it as b2 and go to UPDATE.
REQ-018 UPDATE SHALL last exactly one cycle and then return to WAIT_B0.
REQ-019 A byte whose rx_valid is high during UPDATE SHALL be evaluated as byte 0, i.e. a WAIT_B0 evaluation in the same cycle; it SHALL NOT be dropped.
REQ-020 In WAIT_B1 and WAIT_B2, a gap counter SHALL count cycles without rx_valid.
REQ-021 When the gap counter reaches TIMEOUT_CYC, the FSM SHALL return to WAIT_B0, pulse sync_err and discard the partial packet.
REQ-022 The gap counter SHALL clear on every accepted byte and while in WAIT_B0.
REQ-023 The horizontal delta dx SHALL be the 9-bit signed value {b0[4], b1}.
REQ-024 The vertical delta dy SHALL be the 9-bit signed value {b0[5], b2}.
REQ-025 If b0[6] (X overflow) is set, dx SHALL be forced to 0.
REQ-026 If b0[7] (Y overflow) is set, dy SHALL be forced to 0.
REQ-027 In UPDATE, the next x SHALL be cursor_x + dx.
REQ-028 In UPDATE, the next y SHALL be cursor_y - dy, because PS/2 Y is positive-up and screen Y is positive-down.
REQ-029 The next x and next y SHALL be computed in at least 13-bit signed arithmetic.
REQ-030 Each axis SHALL clamp: a result below 0 gives 0, and a result above the screen limit gives SCREEN_W-1 (x) or SCREEN_H-1 (y). The cursor SHALL never wrap.
REQ-031 In UPDATE, btn_left SHALL load b0[0] and btn_right SHALL load b0[1].
REQ-032 Latency: if b2 is sampled at edge E, then cursor_x, cursor_y, btn_left, btn_right and pkt_valid SHALL change at edge E+1.
REQ-033 pkt_valid SHALL be high for exactly the one cycle following edge E+1.
REQ-034 Outputs SHALL hold their values between packets.
REQ-035 A packet with dx=dy=0 SHALL still pulse pkt_valid.

Reset
REQ-036 While rst_n=0 at a clk edge, the FSM SHALL go to WAIT_B0 and the gap counter, b0, b1 and b2 SHALL clear.
REQ-037 While rst_n=0 at a clk edge, cursor_x SHALL load SCREEN_W/2 (320) and cursor_y SHALL load SCREEN_H/2 (240).
REQ-038 While rst_n=0 at a clk edge, btn_left, btn_right, left_click, right_click, pkt_valid and sync_err SHALL load 0.
REQ-039 A reset asserted mid-packet SHALL abandon that packet; the first byte after release SHALL be treated as byte 0.

Configuration
REQ-040 With macro MOUSE_CLICK_PULSE_EN defined, left_click SHALL pulse for one cycle at edge E+1 when b0[0]=1 and the previous btn_left=0; right_click SHALL behave the same way using b0[1] and btn_right.
REQ-041 Without MOUSE_CLICK_PULSE_EN, left_click and right_click SHALL be constant 0 and no edge-detect logic SHALL be built; btn_left and btn_right are unaffected.

Verification
REQ-042 Reset, then bytes 0x08, 0x0A, 0x05 -> cursor (330, 235), btn 00, pkt_valid pulses once at E+1.
REQ-043 From (330, 235), bytes 0x18, 0x00, 0x00 (dx=-256) -> cursor_x=74; repeat the same packet -> cursor_x=0, i.e. clamped with no wrap.
REQ-044 Byte 0x00, then 0x08, 0x01, 0x01 -> sync_err pulses once on the first byte; cursor moves (+1, -1).
REQ-045 Bytes 0x08, 0x01, then silence for TIMEOUT_CYC cycles -> sync_err pulses; a following 0x09, 0x00, 0x00 -> btn_left=1, left_click pulses only when MOUSE_CLICK_PULSE_EN is defined, cursor unchanged.
REQ-046 Bytes 0x48, 0x7F, 0x00 (X overflow set) -> cursor unchanged, pkt_valid pulses.
REQ-047 Assert rst_n=0 after byte 1 of a packet -> cursor resets to (320, 240); the next 3-byte packet is decoded correctly.

Source files
------------

// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: decodes 3-byte PS/2 mouse packets into a clamped
// screen cursor position and button state.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   rx_data, rx_valid    received PS/2 byte and its one-cycle strobe
//   cursor_x, cursor_y   registered cursor position (0..SCREEN_W-1, 0..SCREEN_H-1)
//   btn_left, btn_right  registered button levels
//   left_click,
//   right_click          one-cycle press pulses (only with MOUSE_CLICK_PULSE_EN)
//   pkt_valid            one-cycle pulse per applied packet
//   sync_err             one-cycle pulse per discarded byte or timed-out packet
//
// Optional feature macro: MOUSE_CLICK_PULSE_EN (click edge detection).
module mouse_cursor_tracker #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [10:0] cursor_x,
    output logic [10:0] cursor_y,
    output logic        btn_left,
    output logic        btn_right,
    output logic        left_click,
    output logic        right_click,
    output logic        pkt_valid,
    output logic        sync_err
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
    localparam logic signed [12:0] X_MAX = 13'(SCREEN_W - 1);
    localparam logic signed [12:0] Y_MAX = 13'(SCREEN_H - 1);
    localparam logic [10:0] X_RST = 11'(SCREEN_W / 2);
    localparam logic [10:0] Y_RST = 11'(SCREEN_H / 2);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_e;

    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [10:0]      cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
    logic             btn_left_q, btn_left_d, btn_right_q, btn_right_d;
    logic             pkt_valid_q, pkt_valid_d, sync_err_q, sync_err_d;

    // Sync bit and middle button are never consumed.
    logic [1:0]       b0_unused;
    assign b0_unused = b0_q[3:2];

    // Movement datapath: deltas, 13-bit signed sums, per-axis clamp.
    logic signed [8:0]  dx, dy;
    logic signed [12:0] nx, ny;
    logic [10:0]        x_clamp, y_clamp;

    always_comb begin
        dx = b0_q[6] ? 9'sd0 : $signed({b0_q[4], b1_q});
        dy = b0_q[7] ? 9'sd0 : $signed({b0_q[5], b2_q});
        nx = $signed({2'b00, cursor_x_q}) + $signed({{4{dx[8]}}, dx});
        // Screen Y grows downward while PS/2 Y grows upward.
        ny = $signed({2'b00, cursor_y_q}) - $signed({{4{dy[8]}}, dy});
        if (nx < 13'sd0)      x_clamp = 11'd0;
        else if (nx > X_MAX)  x_clamp = 11'(X_MAX);
        else                  x_clamp = 11'(nx);
        if (ny < 13'sd0)      y_clamp = 11'd0;
        else if (ny > Y_MAX)  y_clamp = 11'(Y_MAX);
        else                  y_clamp = 11'(ny);
    end

`ifdef MOUSE_CLICK_PULSE_EN
    logic left_click_q, left_click_d, right_click_q, right_click_d;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        cursor_x_d  = cursor_x_q;
        cursor_y_d  = cursor_y_q;
        btn_left_d  = btn_left_q;
        btn_right_d = btn_right_q;
        pkt_valid_d = 1'b0;
        sync_err_d  = 1'b0;
`ifdef MOUSE_CLICK_PULSE_EN
        left_click_d  = 1'b0;
        right_click_d = 1'b0;
`endif
        case (state_q)
            WAIT_B0, UPDATE: begin
                gap_d   = '0;
                state_d = WAIT_B0;
                if (state_q == UPDATE) begin
                    cursor_x_d  = x_clamp;
                    cursor_y_d  = y_clamp;
                    btn_left_d  = b0_q[0];
                    btn_right_d = b0_q[1];
                    pkt_valid_d = 1'b1;
`ifdef MOUSE_CLICK_PULSE_EN
                    left_click_d  = b0_q[0] & ~btn_left_q;
                    right_click_d = b0_q[1] & ~btn_right_q;
`endif
                end
                // A byte arriving during UPDATE is evaluated as a fresh byte 0.
                if (rx_valid) begin
                    if (rx_data[3]) begin
                        b0_d    = rx_data;
                        state_d = WAIT_B1;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            WAIT_B1, WAIT_B2: begin
                if (rx_valid) begin
                    gap_d = '0;
                    if (state_q == WAIT_B1) begin
                        b1_d    = rx_data;
                        state_d = WAIT_B2;
                    end else begin
                        b2_d    = rx_data;
                        state_d = UPDATE;
                    end
                end else if (gap_q == GAP_LAST) begin
                    gap_d      = '0;
                    state_d    = WAIT_B0;
                    sync_err_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = WAIT_B0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_B0;
            gap_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            cursor_x_q  <= X_RST;
            cursor_y_q  <= Y_RST;
            btn_left_q  <= 1'b0;
            btn_right_q <= 1'b0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            cursor_x_q  <= cursor_x_d;
            cursor_y_q  <= cursor_y_d;
            btn_left_q  <= btn_left_d;
            btn_right_q <= btn_right_d;
            pkt_valid_q <= pkt_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

`ifdef MOUSE_CLICK_PULSE_EN
    // Press-edge pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_click_q  <= 1'b0;
            right_click_q <= 1'b0;
        end else begin
            left_click_q  <= left_click_d;
            right_click_q <= right_click_d;
        end
    end
    assign left_click  = left_click_q;
    assign right_click = right_click_q;
`else
    assign left_click  = 1'b0;
    assign right_click = 1'b0;
`endif

    assign cursor_x  = cursor_x_q;
    assign cursor_y  = cursor_y_q;
    assign btn_left  = btn_left_q;
    assign btn_right = btn_right_q;
    assign pkt_valid = pkt_valid_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Testbench for mouse_cursor_tracker: table of packets with hand-computed
// cursor/button results, plus directed sequences for sync errors, timeout,
// back-to-back bytes and mid-packet reset.
module tb_mouse_cursor_tracker;

    localparam int unsigned TO = 16;
`ifdef MOUSE_CLICK_PULSE_EN
    localparam bit CLK_EN = 1'b1;
`else
    localparam bit CLK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [10:0] cursor_x, cursor_y;
    logic        btn_left, btn_right, left_click, right_click, pkt_valid, sync_err;

    mouse_cursor_tracker #(
        .SCREEN_W   (640),
        .SCREEN_H   (480),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .left_click (left_click),
        .right_click(right_click),
        .pkt_valid  (pkt_valid),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    // Count sync_err pulses just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sync_err) err_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         x, y;
        logic       bl, br;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    // Called in the UPDATE cycle; checks the E+1 latency and one-cycle pulse.
    task automatic wait_pkt(input string nm, input int x, input int y, input bit bl,
                            input bit br, input bit lc, input bit rc);
        chk({nm, ".pkt_early"}, pkt_valid, 0);
        @(negedge clk);
        chk({nm, ".pkt_valid"}, pkt_valid, 1);
        chk({nm, ".x"}, cursor_x, x);
        chk({nm, ".y"}, cursor_y, y);
        chk({nm, ".btn_l"}, btn_left, bl);
        chk({nm, ".btn_r"}, btn_right, br);
        chk({nm, ".click_l"}, left_click, lc);
        chk({nm, ".click_r"}, right_click, rc);
        @(negedge clk);
        chk({nm, ".pkt_end"}, pkt_valid, 0);
        chk({nm, ".click_l_end"}, left_click, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  n;
        int  err0;
        bit  pbl, pbr;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        tbl[0]  = '{8'h08, 8'h0A, 8'h05, 330, 235, 1'b0, 1'b0};
        tbl[1]  = '{8'h18, 8'h00, 8'h00,  74, 235, 1'b0, 1'b0};
        tbl[2]  = '{8'h18, 8'h00, 8'h00,   0, 235, 1'b0, 1'b0};
        tbl[3]  = '{8'h08, 8'h01, 8'h01,   1, 234, 1'b0, 1'b0};
        tbl[4]  = '{8'h48, 8'h7F, 8'h00,   1, 234, 1'b0, 1'b0};
        tbl[5]  = '{8'h0B, 8'h00, 8'h00,   1, 234, 1'b1, 1'b1};
        tbl[6]  = '{8'h89, 8'h00, 8'h7F,   1, 234, 1'b1, 1'b0};
        tbl[7]  = '{8'h08, 8'h00, 8'h00,   1, 234, 1'b0, 1'b0};
        tbl[8]  = '{8'h28, 8'h00, 8'h00,   1, 479, 1'b0, 1'b0};
        tbl[9]  = '{8'h08, 8'hFF, 8'h00, 256, 479, 1'b0, 1'b0};
        tbl[10] = '{8'h0A, 8'hFF, 8'h00, 511, 479, 1'b0, 1'b1};
        tbl[11] = '{8'h0A, 8'hFF, 8'h00, 639, 479, 1'b0, 1'b1};
        tbl[12] = '{8'h39, 8'hFF, 8'h01, 638, 479, 1'b1, 1'b0};
        tbl[13] = '{8'h08, 8'h00, 8'h7F, 638, 352, 1'b0, 1'b0};
        tbl[14] = '{8'h08, 8'h00, 8'hFF, 638,  97, 1'b0, 1'b0};
        tbl[15] = '{8'h08, 8'h00, 8'hFF, 638,   0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.x", cursor_x, 320);
        chk("rst.y", cursor_y, 240);
        chk("rst.btn", {btn_left, btn_right}, 0);
        chk("rst.pulses", {left_click, right_click, pkt_valid, sync_err}, 0);
        rst_n = 1'b1;

        // Packet table
        pbl = 1'b0;
        pbr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send3(tbl[i].b0, tbl[i].b1, tbl[i].b2);
            wait_pkt($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].bl, tbl[i].br,
                     CLK_EN & tbl[i].bl & ~pbl, CLK_EN & tbl[i].br & ~pbr);
            pbl = tbl[i].bl;
            pbr = tbl[i].br;
        end
        chk("tbl.sync_err", err_seen, 0);

        // Discarded non-sync byte, then a good packet
        do_reset();
        err0 = err_seen;
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        chk("sync.err_once", err_seen - err0, 1);
        send3(8'h08, 8'h01, 8'h01);
        wait_pkt("sync", 321, 239, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sync.err_after", err_seen - err0, 1);

        // Timeout after exactly TO silent cycles
        do_reset();
        err0 = err_seen;
        send_byte(8'h08);
        send_byte(8'h01);
        n = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            @(negedge clk);
            if (sync_err) begin
                n = i;
                break;
            end
        end
        chk("timeout.cycles", n, TO);
        chk("timeout.err", err_seen - err0, 1);
        send3(8'h09, 8'h00, 8'h00);
        wait_pkt("timeout.next", 320, 240, 1'b1, 1'b0, CLK_EN, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold.btn_l", btn_left, 1);
        chk("hold.x", cursor_x, 320);

        // Gaps one cycle short of the timeout are tolerated
        err0 = err_seen;
        send_byte(8'h08);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h02);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h00);
        wait_pkt("gap_ok", 322, 240, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_ok.err", err_seen - err0, 0);

        // Byte 0 arriving during UPDATE is kept
        send3(8'h08, 8'h01, 8'h00);
        chk("b2b.pkt_early", pkt_valid, 0);
        rx_data  = 8'h08;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("b2b.pkt_valid", pkt_valid, 1);
        chk("b2b.x", cursor_x, 323);
        send_byte(8'h01);
        send_byte(8'h01);
        wait_pkt("b2b.second", 324, 239, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b.err", err_seen - err0, 0);

        // Reset in the middle of a packet
        send_byte(8'h08);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.x", cursor_x, 320);
        chk("midrst.y", cursor_y, 240);
        rst_n = 1'b1;
        send3(8'h28, 8'h03, 8'hFE);
        wait_pkt("midrst.next", 323, 242, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
